// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the byte-serial packed-BCD adder sequencer.
package bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit limit and decimal adjust, sized to the 5-bit digit sum.
   localparam logic [4:0] BCD_DIGIT_MAX = 5'd9;
   localparam logic [4:0] BCD_ADJ       = 5'd6;

   // Byte-counter width; never narrower than one bit.
   function automatic int cnt_width(input int nbytes);
      return (nbytes <= 1) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/bcd2_add.sv
// Combinational 2-digit packed-BCD adder stage (one byte, carry chained
// from the low digit to the high digit).
module bcd2_add
   import bcd_seq_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);

   // Returns {carry, digit}; invalid input digits get the same rule unchanged.
   function automatic logic [4:0] digit_add(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       c);
      logic [4:0] t;
      logic [4:0] adj;
      t   = {1'b0, x} + {1'b0, y} + {4'b0, c};
      adj = t + BCD_ADJ;
      if (t > BCD_DIGIT_MAX) return {1'b1, adj[3:0]};
      else                   return {1'b0, t[3:0]};
   endfunction

   logic [4:0] lo;
   logic [4:0] hi;

   assign lo = digit_add(a[3:0], b[3:0], ci);
   assign hi = digit_add(a[7:4], b[7:4], lo[4]);
   assign s  = {hi[3:0], lo[3:0]};
   assign co = hi[4];

endmodule

// File: rtl/bcd_mb_add_seq.sv
// Byte-serial multi-byte packed-BCD adder: accepts A, B and carry-in, runs one
// bcd2_add stage per cycle from the least-significant byte, and presents the
// assembled sum and carry-out on an output valid/ready handshake.
// Optional digit checker: define BCD_SEQ_CHECK_EN to flag digits > 9 on err.
module bcd_mb_add_seq
   import bcd_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam int CW = cnt_width(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic                carry;
   logic [8*NBYTES-1:0] a_sr;
   logic [8*NBYTES-1:0] b_sr;
   logic [8*NBYTES-1:0] sum_sr;
   logic [8*NBYTES-1:0] sum_next;
   logic [7:0]          s_byte;
   logic                s_co;
   logic                accept;

   assign accept = (state == IDLE) && in_valid && in_ready;

   bcd2_add u_add (
      .a  (a_sr[7:0]),
      .b  (b_sr[7:0]),
      .ci (carry),
      .s  (s_byte),
      .co (s_co)
   );

   // Next sum image: shift right one byte and insert the new byte at the top.
   always_comb begin
      // NOTE: default first, then override a slice, so no latch is inferred.
      sum_next                      = sum_sr >> 8;
      sum_next[8*NBYTES-1 -: 8]     = s_byte;
   end

   // Control FSM: handshakes, byte counter and the chained decimal carry.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  in_ready <= 1'b0;
                  carry    <= cin;
                  cnt      <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               carry <= s_co;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand shift registers: load on accept, consume one byte per RUN cycle.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath with no reset; contents only matter after a load.
      if (accept) begin
         a_sr <= a;
         b_sr <= b;
      end else if (state == RUN) begin
         a_sr <= a_sr >> 8;
         b_sr <= b_sr >> 8;
      end
   end

   // Sum shift register: visible output, so it returns to zero on reset.
   always_ff @(posedge clk) begin
      if (rst)                sum_sr <= '0;
      else if (state == RUN)  sum_sr <= sum_next;
   end

   assign sum  = sum_sr;
   assign cout = carry;

`ifdef BCD_SEQ_CHECK_EN
   function automatic logic bad_byte(input logic [7:0] x);
      return ({1'b0, x[3:0]} > BCD_DIGIT_MAX) || ({1'b0, x[7:4]} > BCD_DIGIT_MAX);
   endfunction

   logic err_q;

   // Sticky invalid-digit flag, cleared when new operands are accepted.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (accept)
         err_q <= 1'b0;
      else if ((state == RUN) && (bad_byte(a_sr[7:0]) || bad_byte(b_sr[7:0])))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mb_add_seq.sv
// Directed self-checking bench for bcd_mb_add_seq with NBYTES = 4.
module tb_bcd_mb_add_seq;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

`ifdef BCD_SEQ_CHECK_EN
   localparam logic BAD_ERR = 1'b1;
`else
   localparam logic BAD_ERR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;

   bcd_mb_add_seq #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, then present operands for one accept edge.
   task automatic send(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      cin      = cv;
      tick();
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
   endtask

   // Bounded wait for out_valid; the count of cycles after the accept edge is checked.
   task automatic wait_result(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(NBYTES));
   endtask

   task automatic run_txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic exp_err);
      send(tag, av, bv, cv);
      wait_result(tag);
      check({tag, "_sum"},  sum,  exp_sum);
      check({tag, "_cout"}, cout, exp_cout);
      check({tag, "_err"},  err,  exp_err);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ov_clr"}, out_valid, 1'b0);
      check({tag, "_rdy_nxt"}, in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();

      // Reset state while rst is high
      check("rst_in_ready",  in_ready,  1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum",       sum,       '0);
      check("rst_cout",      cout,      1'b0);
      check("rst_err",       err,       1'b0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1'b1);

      // Case 1-3: basic adds, decimal carry across bytes, full-width overflow
      run_txn("t1",  32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0);
      run_txn("t2a", 32'h00000058, 32'h00000049, 1'b0, 32'h00000107, 1'b0, 1'b0);
      run_txn("t2b", 32'h00000026, 32'h00000015, 1'b1, 32'h00000042, 1'b0, 1'b0);
      run_txn("t3a", 32'h99999999, 32'h99999999, 1'b0, 32'h99999998, 1'b1, 1'b0);
      run_txn("t3b", 32'h99999999, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);

      // Case 4: back-pressure in DONE with a stray in_valid pulse
      send("t4", 32'h00001234, 32'h00005678, 1'b0);
      wait_result("t4");
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            a        = 32'h00000011;
            b        = 32'h00000022;
         end
         tick();
         in_valid = 1'b0;
         a        = '0;
         b        = '0;
         check("t4_hold_ov",  out_valid, 1'b1);
         check("t4_hold_sum", sum,       32'h00006912);
         check("t4_hold_co",  cout,      1'b0);
         check("t4_hold_rdy", in_ready,  1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_rel_rdy", in_ready,  1'b1);
      check("t4_rel_ov",  out_valid, 1'b0);
      repeat (NBYTES + 2) tick();
      check("t4_no_accept_ov",  out_valid, 1'b0);
      check("t4_no_accept_rdy", in_ready,  1'b1);

      // Case 5: invalid digit flag, then cleared on the next valid transaction
      run_txn("t5a", 32'h0000000A, 32'h00000001, 1'b0, 32'h00000011, 1'b0, BAD_ERR);
      run_txn("t5b", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);

      // Case 6: reset in the second RUN cycle aborts the transaction
      send("t6", 32'h00000099, 32'h00000099, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("t6_rst_ov",  out_valid, 1'b0);
      check("t6_rst_sum", sum,       '0);
      check("t6_rst_co",  cout,      1'b0);
      check("t6_rst_rdy", in_ready,  1'b0);
      rst = 1'b0;
      run_txn("t6b", 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
